lif_neuron_array: RTL
=====================

Name: lif_neuron_array

Overview:
- Parametrised leaky-integrate-and-fire neuron array, N_CH independent channels.
- Each channel integrates a per-channel input current on a shared step tick, applies shift-based leak and fires at a runtime threshold, then enters a refractory period.
- Sits between the stimulus source (ramp generator or host registers) and the spike consumers (LED drivers, spike counters).
- Armed by a synchronised start button.

Parameters:
- N_CH, 4, number of neuron channels.
- W, 8, membrane/current/threshold width in bits (W >= 4).
- LEAK_SHIFT, 3, leak = V >> LEAK_SHIFT (1 <= LEAK_SHIFT < W).
- TICKS_PER_STEP, 100000, clk cycles per integration step (>= 2); default gives 1 ms at 100 MHz.
- REFRACT_STEPS, 2, steps held at 0 after a spike (0 = none).
- CNT_W, 16, spike counter width (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_btn  in  1  asynchronous start button.
- thresh  in  W  firing threshold, shared by all channels; sampled at each step.
- i_in  in  N_CH*W  input currents; channel k occupies [k*W +: W]; sampled at each step.
- running  out  1  high once armed.
- step_tick  out  1  one-cycle pulse at each integration step.
- spike  out  N_CH  one-cycle spike pulse per channel.
- vmem  out  N_CH*W  membrane potentials, same packing as i_in.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high: all state updates on posedge clk only, and rst=1 at a posedge clears everything.
  - Reset values: running=0, step_tick=0, spike=0, vmem=0, refractory counters=0, synchroniser=0, step counter=0.
  - Reset mid-step discards all accumulated state; there is no partial update.
- Arming:
  - start_btn passes a 2-flop synchroniser, then a rising-edge detect.
  - The first rising edge sets running=1; running stays set until rst.
  - Further presses are ignored.
- Step counter:
  - Free-runs 0..TICKS_PER_STEP-1 and wraps.
  - step_tick is registered, high for the cycle after the counter reads TICKS_PER_STEP-1.
  - step_tick pulses regardless of running.
- Channel update:
  - Occurs on a cycle with step_tick=1 and running=1; otherwise channels hold.
  - Refractory case (refr != 0): V <= 0, refr <= refr-1, spike=0, i_in ignored.
  - Otherwise: leak = V >> LEAK_SHIFT (floor); sum = V - leak + I, computed in W+1 bits, never negative.
  - Saturation: if sum > 2^W-1, clamp sum to 2^W-1.
  - Fire (sum >= thresh): spike=1, V <= 0, refr <= REFRACT_STEPS.
  - No fire: V <= sum, spike=0.
- Latency and pulse shape:
  - spike and vmem update on the clock edge that ends the step_tick cycle, i.e. one cycle after step_tick.
  - spike lasts exactly one cycle.
- Edge cases:
  - thresh=0: every non-refractory step fires.
  - thresh change mid-step: takes effect at the next step only.
  - i_in=0: V decays to the fixed point where leak=0, i.e. V < 2^LEAK_SHIFT.
- Channels are fully independent; the same step may fire any subset of channels.

Optional Feature:
- Macro LIF_SPIKE_COUNT_EN.
- Defined:
  - Adds output port spike_cnt, N_CH*CNT_W bits, one counter per channel, same packing.
  - Each counter increments on its channel's spike and saturates at 2^CNT_W-1 (no wrap).
  - Counters reset to 0 on rst.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Package lif_pkg:
  - Default constants: CLK_FREQ_HZ=100_000_000, TICKS_PER_MS, default W and LEAK_SHIFT.
  - Function sat_add(W) for the saturating sum.
- Sub-module lif_channel: one neuron (V register, refractory counter, spike flop, optional counter).
  - Instanced N_CH times via generate.
  - Top level holds the synchroniser, arming logic and step counter.

Test Plan:
1. Bench parameters: TICKS_PER_STEP=4, W=8, LEAK_SHIFT=3, REFRACT_STEPS=2, thresh=100, i_in ch0=20. Press start.
   - Required vmem ch0 on successive steps: 20, 38, 54, 68, 80, 90, 99.
   - Step 8: spike ch0=1 for one cycle, vmem=0.
   - Steps 9 and 10: vmem=0. Step 11: vmem=20.
2. Without start press: step_tick pulses every 4 cycles; vmem stays 0 and spike stays 0 for 50 steps. A second start press after arming changes nothing.
3. Saturation: thresh=255, i_in=255.
   - Step 1: sum=255 clamps, fires, vmem=0.
   - With REFRACT_STEPS=0: fires every step.
4. Per-channel independence: i_in ch1=0, ch2=100, ch3=255 with thresh=100.
   - ch2 and ch3 fire at step 1; ch1 never fires.
   - spike mask 4'b1100 appears in a single cycle.
5. Reset mid-operation: assert rst for 1 cycle at V=54.
   - Next cycle: vmem=0, running=0, counter=0.
   - Integration restarts only after a new start edge.
6. LIF_SPIKE_COUNT_EN with CNT_W=2, thresh=0: spike_cnt ch0 reads 1, 2, 3, 3, 3 over 5 fires.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants and the saturating-add helper for the LIF neuron array.
package lif_pkg;

  localparam int CLK_FREQ_HZ    = 100_000_000;
  localparam int TICKS_PER_MS   = CLK_FREQ_HZ / 1000;
  localparam int DEF_W          = 8;
  localparam int DEF_LEAK_SHIFT = 3;

  // Unsigned a + b clamped to 2^w-1; w must be below 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] max_v;
    s     = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    return (s > max_v) ? max_v[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/lif_channel.sv
// One leaky-integrate-and-fire neuron: membrane, refractory counter, spike flop.
// LIF_SPIKE_COUNT_EN adds a saturating per-channel spike counter.
module lif_channel
  import lif_pkg::*;
#(
  parameter int W             = DEF_W,
  parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT,
  parameter int REFRACT_STEPS = 2
`ifdef LIF_SPIKE_COUNT_EN
  , parameter int CNT_W       = 16
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] thresh,
  input  logic [W-1:0] i_in,
  output logic         spike,
  output logic [W-1:0] vmem
`ifdef LIF_SPIKE_COUNT_EN
  , output logic [CNT_W-1:0] spike_cnt
`endif
);

  localparam int REFR_W = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;

  logic [W-1:0]      v_q, v_d;
  logic [REFR_W-1:0] refr_q, refr_d;
  logic              spike_q, spike_d;
  logic [W-1:0]      leak;
  logic [31:0]       sum32;

  always_comb begin
    v_d     = v_q;
    refr_d  = refr_q;
    spike_d = 1'b0;
    leak    = v_q >> LEAK_SHIFT;
    // v_q >= leak, so the difference never wraps before the saturating add.
    sum32   = sat_add(32'(v_q - leak), 32'(i_in), W);
    if (en) begin
      if (refr_q != '0) begin
        v_d    = '0;
        refr_d = refr_q - REFR_W'(1);
      end else if (sum32 >= 32'(thresh)) begin
        spike_d = 1'b1;
        v_d     = '0;
        refr_d  = REFR_W'(REFRACT_STEPS);
      end else begin
        v_d = sum32[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      refr_q  <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      refr_q  <= refr_d;
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;
  assign vmem  = v_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (spike_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign spike_cnt = cnt_q;
`endif

endmodule

// File: rtl/lif_neuron_array.sv
// N_CH-channel LIF neuron array: start-button synchroniser, arming and step timer.
// LIF_SPIKE_COUNT_EN adds the spike_cnt output port.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int W              = DEF_W,
  parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
  parameter int TICKS_PER_STEP = TICKS_PER_MS,
  parameter int REFRACT_STEPS  = 2
`ifdef LIF_SPIKE_COUNT_EN
  , parameter int CNT_W        = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_btn,
  input  logic [W-1:0]      thresh,
  input  logic [N_CH*W-1:0] i_in,
  output logic              running,
  output logic              step_tick,
  output logic [N_CH-1:0]   spike,
  output logic [N_CH*W-1:0] vmem
`ifdef LIF_SPIKE_COUNT_EN
  , output logic [N_CH*CNT_W-1:0] spike_cnt
`endif
);

  localparam int TC_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

  logic            sync1_q, sync2_q, prev_q;
  logic            running_q, running_d;
  logic [TC_W-1:0] tcnt_q, tcnt_d;
  logic            tick_q, tick_d;
  logic            last_tick;

  always_comb begin
    last_tick = (tcnt_q == TC_W'(TICKS_PER_STEP - 1));
    tcnt_d    = last_tick ? '0 : tcnt_q + TC_W'(1);
    tick_d    = last_tick;
    // Only the first synchronised rising edge matters; later presses are absorbed.
    running_d = running_q | (sync2_q & ~prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      running_q <= 1'b0;
      tcnt_q    <= '0;
      tick_q    <= 1'b0;
    end else begin
      sync1_q   <= start_btn;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      running_q <= running_d;
      tcnt_q    <= tcnt_d;
      tick_q    <= tick_d;
    end
  end

  assign running   = running_q;
  assign step_tick = tick_q;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      lif_channel #(
        .W             (W),
        .LEAK_SHIFT    (LEAK_SHIFT),
        .REFRACT_STEPS (REFRACT_STEPS)
`ifdef LIF_SPIKE_COUNT_EN
        , .CNT_W       (CNT_W)
`endif
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .en     (tick_q & running_q),
        .thresh (thresh),
        .i_in   (i_in[gi*W +: W]),
        .spike  (spike[gi]),
        .vmem   (vmem[gi*W +: W])
`ifdef LIF_SPIKE_COUNT_EN
        , .spike_cnt (spike_cnt[gi*CNT_W +: CNT_W])
`endif
      );
    end
  endgenerate

endmodule
